// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven clock/calendar setting FSM.
// Edits a shadow copy of the time, then loads it into the timekeeper.
module time_set_ctrl #(
  parameter int YEAR_MIN  = 2000,
  parameter int YEAR_MAX  = 2099,
  parameter int TIMEOUT_S = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_1hz,
  input  logic        btn_mode,
  input  logic        btn_next,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic [15:0] cur_year,
  input  logic [5:0]  cur_month,
  input  logic [10:0] cur_day,
  input  logic [10:0] cur_week,
  input  logic [10:0] cur_hour,
  input  logic [10:0] cur_minute,
  input  logic [10:0] cur_second,
  output logic [15:0] set_year,
  output logic [5:0]  set_month,
  output logic [10:0] set_day,
  output logic [10:0] set_week,
  output logic [10:0] set_hour,
  output logic [10:0] set_minute,
  output logic [10:0] set_second,
  output logic        load,
  output logic        hold,
  output logic [2:0]  field_sel,
  output logic        blink
);

  localparam int IW = (TIMEOUT_S < 2) ? 1 : $clog2(TIMEOUT_S + 1);
  localparam logic [15:0] YMIN = 16'(YEAR_MIN);
  localparam logic [15:0] YMAX = 16'(YEAR_MAX);

  typedef enum logic [3:0] {
    RUN, S_YEAR, S_MONTH, S_DAY, S_WEEK,
    S_HOUR, S_MIN, S_SEC, COMMIT
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] year_q, year_d;
  logic [5:0]  month_q, month_d;
  logic [10:0] day_q, day_d;
  logic [10:0] week_q, week_d;
  logic [10:0] hour_q, hour_d;
  logic [10:0] min_q, min_d;
  logic [10:0] sec_q, sec_d;
  logic        load_q, load_d;
  logic        hold_q, hold_d;
  logic        blink_q, blink_d;
  logic [2:0]  sel_q, sel_d;
  logic [IW-1:0] idle_q, idle_d;

  logic        act_mode, act_next, act_up, act_dn;
  logic        btn_any, in_edit;
  logic [10:0] dim_cur, dim_new;

  function automatic logic is_leap(input logic [15:0] y);
    return ((y[1:0] == 2'b00) && ((y % 16'd100) != 16'd0))
        || ((y % 16'd400) == 16'd0);
  endfunction

  function automatic logic [10:0] dim(input logic [15:0] y,
                                      input logic [5:0] m);
    logic [10:0] r;
    r = 11'd31;
    case (m)
      6'd2:                    r = is_leap(y) ? 11'd29 : 11'd28;
      6'd4, 6'd6, 6'd9, 6'd11: r = 11'd30;
      default:                 r = 11'd31;
    endcase
    return r;
  endfunction

  // Button priority: mode > next > up > down, only one acts.
  always_comb begin
    btn_any  = btn_mode | btn_next | btn_up | btn_down;
    act_mode = btn_mode;
    act_next = !btn_mode && btn_next;
    act_up   = !btn_mode && !btn_next && btn_up;
    act_dn   = !btn_mode && !btn_next && !btn_up && btn_down;
    in_edit  = (state_q != RUN) && (state_q != COMMIT);
    dim_cur  = dim(year_q, month_q);
  end

  // Next-state, field edits, idle timeout and registered outputs.
  always_comb begin
    state_d = state_q;
    year_d  = year_q;
    month_d = month_q;
    day_d   = day_q;
    week_d  = week_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    blink_d = blink_q;
    idle_d  = idle_q;
    dim_new = dim_cur;
    if (state_q == RUN) begin
      if (btn_mode) begin
        year_d  = cur_year;
        month_d = cur_month;
        day_d   = cur_day;
        week_d  = cur_week;
        hour_d  = cur_hour;
        min_d   = cur_minute;
        sec_d   = cur_second;
        state_d = S_YEAR;
        idle_d  = '0;
      end
    end else if (state_q == COMMIT) begin
      state_d = RUN;
    end else begin
      unique case (1'b1)
        act_mode: state_d = RUN;
        act_next: begin
          case (state_q)
            S_YEAR:  state_d = S_MONTH;
            S_MONTH: state_d = S_DAY;
            S_DAY:   state_d = S_WEEK;
            S_WEEK:  state_d = S_HOUR;
            S_HOUR:  state_d = S_MIN;
            S_MIN:   state_d = S_SEC;
            default: state_d = COMMIT;
          endcase
        end
        act_up, act_dn: begin
          blink_d = 1'b1;
          case (state_q)
            S_YEAR: begin
              if (act_up)
                year_d = (year_q >= YMAX || year_q < YMIN)
                       ? YMIN : year_q + 16'd1;
              else
                year_d = (year_q <= YMIN || year_q > YMAX)
                       ? YMAX : year_q - 16'd1;
            end
            S_MONTH: begin
              if (act_up)
                month_d = (month_q >= 6'd12) ? 6'd1 : month_q + 6'd1;
              else
                month_d = (month_q <= 6'd1) ? 6'd12 : month_q - 6'd1;
            end
            S_DAY: begin
              if (act_up)
                day_d = (day_q >= dim_cur) ? 11'd1 : day_q + 11'd1;
              else
                day_d = (day_q <= 11'd1) ? dim_cur : day_q - 11'd1;
            end
            S_WEEK: begin
              if (act_up)
                week_d = (week_q >= 11'd7) ? 11'd1 : week_q + 11'd1;
              else
                week_d = (week_q <= 11'd1) ? 11'd7 : week_q - 11'd1;
            end
            S_HOUR: begin
              if (act_up)
                hour_d = (hour_q >= 11'd23) ? 11'd0 : hour_q + 11'd1;
              else
                hour_d = (hour_q == 11'd0) ? 11'd23 : hour_q - 11'd1;
            end
            S_MIN: begin
              if (act_up)
                min_d = (min_q >= 11'd59) ? 11'd0 : min_q + 11'd1;
              else
                min_d = (min_q == 11'd0) ? 11'd59 : min_q - 11'd1;
            end
            default: begin
              if (act_up)
                sec_d = (sec_q >= 11'd59) ? 11'd0 : sec_q + 11'd1;
              else
                sec_d = (sec_q == 11'd0) ? 11'd59 : sec_q - 11'd1;
            end
          endcase
          // A year or month change can shrink the month under the day.
          dim_new = dim(year_d, month_d);
          if (day_d > dim_new) day_d = dim_new;
        end
        default: begin
          if (tick_1hz) begin
            if (int'(idle_q) + 1 >= TIMEOUT_S) begin
              state_d = RUN;
            end else begin
              idle_d  = idle_q + 1'b1;
              blink_d = ~blink_q;
            end
          end
        end
      endcase
    end
    if (btn_any || !in_edit) idle_d = '0;
    if (state_d == RUN || state_d == COMMIT) blink_d = 1'b0;
    load_d = (state_d == COMMIT);
    hold_d = (state_d != RUN);
    case (state_d)
      S_YEAR:  sel_d = 3'd1;
      S_MONTH: sel_d = 3'd2;
      S_DAY:   sel_d = 3'd3;
      S_WEEK:  sel_d = 3'd4;
      S_HOUR:  sel_d = 3'd5;
      S_MIN:   sel_d = 3'd6;
      S_SEC:   sel_d = 3'd7;
      default: sel_d = 3'd0;
    endcase
  end

  // State, shadow time and outputs; synchronous reset wins over all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      year_q  <= 16'd2023;
      month_q <= 6'd5;
      day_q   <= 11'd9;
      week_q  <= 11'd2;
      hour_q  <= 11'd11;
      min_q   <= 11'd59;
      sec_q   <= 11'd58;
      load_q  <= 1'b0;
      hold_q  <= 1'b0;
      blink_q <= 1'b0;
      sel_q   <= 3'd0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      year_q  <= year_d;
      month_q <= month_d;
      day_q   <= day_d;
      week_q  <= week_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      load_q  <= load_d;
      hold_q  <= hold_d;
      blink_q <= blink_d;
      sel_q   <= sel_d;
      idle_q  <= idle_d;
    end
  end

  assign set_year   = year_q;
  assign set_month  = month_q;
  assign set_day    = day_q;
  assign set_week   = week_q;
  assign set_hour   = hour_q;
  assign set_minute = min_q;
  assign set_second = sec_q;
  assign load       = load_q;
  assign hold       = hold_q;
  assign blink      = blink_q;
  assign field_sel  = sel_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed scenario tests for time_set_ctrl.
// Inputs change on negedge; outputs are sampled on negedge.
module tb_time_set_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick_1hz = 1'b0;
  logic        btn_mode = 1'b0, btn_next = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0;
  logic [15:0] cur_year = '0;
  logic [5:0]  cur_month = '0;
  logic [10:0] cur_day = '0, cur_week = '0, cur_hour = '0;
  logic [10:0] cur_minute = '0, cur_second = '0;
  logic [15:0] set_year;
  logic [5:0]  set_month;
  logic [10:0] set_day, set_week, set_hour, set_minute, set_second;
  logic        load, hold, blink;
  logic [2:0]  field_sel;

  int total = 0;
  int bad = 0;
  int load_cnt = 0;

  localparam logic [76:0] RST_VAL =
    {16'd2023, 6'd5, 11'd9, 11'd2, 11'd11, 11'd59, 11'd58};

  wire [76:0] set_all = {set_year, set_month, set_day, set_week,
                         set_hour, set_minute, set_second};

  time_set_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_next(btn_next),
    .btn_up(btn_up), .btn_down(btn_down),
    .cur_year(cur_year), .cur_month(cur_month), .cur_day(cur_day),
    .cur_week(cur_week), .cur_hour(cur_hour),
    .cur_minute(cur_minute), .cur_second(cur_second),
    .set_year(set_year), .set_month(set_month), .set_day(set_day),
    .set_week(set_week), .set_hour(set_hour),
    .set_minute(set_minute), .set_second(set_second),
    .load(load), .hold(hold), .field_sel(field_sel), .blink(blink)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load === 1'b1) load_cnt++;

  task automatic press(input logic m, input logic n,
                       input logic u, input logic d);
    @(negedge clk);
    btn_mode = m; btn_next = n; btn_up = u; btn_down = d;
    @(negedge clk);
    btn_mode = 0; btn_next = 0; btn_up = 0; btn_down = 0;
  endtask

  task automatic tick();
    @(negedge clk); tick_1hz = 1;
    @(negedge clk); tick_1hz = 0;
  endtask

  task automatic set_cur(input int y, input int mo, input int d,
                         input int w, input int h, input int mi,
                         input int s);
    cur_year = 16'(y); cur_month = 6'(mo); cur_day = 11'(d);
    cur_week = 11'(w); cur_hour = 11'(h);
    cur_minute = 11'(mi); cur_second = 11'(s);
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL reset_hold got=%0b want=0", hold); end
    total++; if (load !== 1'b0) begin bad++; $display("FAIL reset_load got=%0b want=0", load); end
    total++; if (blink !== 1'b0) begin bad++; $display("FAIL reset_blink got=%0b want=0", blink); end
    total++; if (field_sel !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d want=0", field_sel); end
    total++; if (set_all !== RST_VAL) begin bad++; $display("FAIL reset_set got=%h want=%h", set_all, RST_VAL); end
    rst_n = 1;
  endtask

  task automatic test_run_ignore();
    set_cur(2030, 7, 7, 7, 7, 7, 7);
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    press(0, 0, 0, 1);
    total++; if (field_sel !== 3'd0) begin bad++; $display("FAIL run_sel got=%0d want=0", field_sel); end
    total++; if (hold !== 1'b0) begin bad++; $display("FAIL run_hold got=%0b want=0", hold); end
    total++; if (set_all !== RST_VAL) begin bad++; $display("FAIL run_set got=%h want=%h", set_all, RST_VAL); end
  endtask

  task automatic test_leap_edit();
    int l0;
    logic [76:0] exp;
    set_cur(2024, 2, 29, 4, 10, 0, 0);
    press(1, 0, 0, 0);
    total++; if (field_sel !== 3'd1) begin bad++; $display("FAIL enter_sel got=%0d want=1", field_sel); end
    total++; if (hold !== 1'b1) begin bad++; $display("FAIL enter_hold got=%0b want=1", hold); end
    total++; if (set_year !== 16'd2024) begin bad++; $display("FAIL enter_year got=%0d want=2024", set_year); end
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    total++; if (set_month !== 6'd3) begin bad++; $display("FAIL leap_month got=%0d want=3", set_month); end
    total++; if (set_day !== 11'd29) begin bad++; $display("FAIL leap_day got=%0d want=29", set_day); end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL up_blink got=%0b want=1", blink); end
    l0 = load_cnt;
    repeat (5) press(0, 1, 0, 0);
    total++; if (field_sel !== 3'd7) begin bad++; $display("FAIL sec_sel got=%0d want=7", field_sel); end
    press(0, 1, 0, 0);
    total++; if (load !== 1'b1 || hold !== 1'b1) begin bad++; $display("FAIL commit got=%0b%0b want=11", load, hold); end
    total++; if (field_sel !== 3'd0) begin bad++; $display("FAIL commit_sel got=%0d want=0", field_sel); end
    @(negedge clk);
    total++; if (load !== 1'b0 || hold !== 1'b0) begin bad++; $display("FAIL post_commit got=%0b%0b want=00", load, hold); end
    repeat (3) @(negedge clk);
    total++; if (load_cnt - l0 != 1) begin bad++; $display("FAIL load_once got=%0d want=1", load_cnt - l0); end
    exp = {16'd2024, 6'd3, 11'd29, 11'd4, 11'd10, 11'd0, 11'd0};
    total++; if (set_all !== exp) begin bad++; $display("FAIL commit_set got=%h want=%h", set_all, exp); end
  endtask

  task automatic test_feb_clamp();
    int yrs[3] = '{2023, 2000, 2100};
    int exp[3] = '{28, 29, 28};
    int l0;
    l0 = load_cnt;
    for (int i = 0; i < 3; i++) begin
      set_cur(yrs[i], 1, 31, 1, 0, 0, 0);
      press(1, 0, 0, 0);
      press(0, 1, 0, 0);
      press(0, 0, 1, 0);
      total++; if (set_month !== 6'd2) begin bad++; $display("FAIL feb_month y=%0d got=%0d want=2", yrs[i], set_month); end
      total++; if (set_day !== 11'(exp[i])) begin bad++; $display("FAIL feb_clamp y=%0d got=%0d want=%0d", yrs[i], set_day, exp[i]); end
      press(1, 0, 0, 0);
      total++; if (hold !== 1'b0) begin bad++; $display("FAIL abort_hold y=%0d got=%0b want=0", yrs[i], hold); end
    end
    total++; if (load_cnt != l0) begin bad++; $display("FAIL abort_load got=%0d want=%0d", load_cnt, l0); end
  endtask

  task automatic test_wrap();
    logic [76:0] exp;
    set_cur(2000, 1, 1, 7, 23, 59, 59);
    press(1, 0, 0, 0);
    press(0, 0, 0, 1);
    total++; if (set_year !== 16'd2099) begin bad++; $display("FAIL year_wrap got=%0d want=2099", set_year); end
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    total++; if (set_day !== 11'd31) begin bad++; $display("FAIL day_wrap got=%0d want=31", set_day); end
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    total++; if (set_week !== 11'd1) begin bad++; $display("FAIL week_wrap got=%0d want=1", set_week); end
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    total++; if (set_hour !== 11'd0) begin bad++; $display("FAIL hour_wrap got=%0d want=0", set_hour); end
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    total++; if (set_minute !== 11'd0) begin bad++; $display("FAIL min_wrap got=%0d want=0", set_minute); end
    press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    total++; if (set_second !== 11'd58) begin bad++; $display("FAIL sec_down got=%0d want=58", set_second); end
    press(1, 0, 0, 0);
    exp = {16'd2099, 6'd1, 11'd31, 11'd1, 11'd0, 11'd0, 11'd58};
    total++; if (set_all !== exp) begin bad++; $display("FAIL abort_frozen got=%h want=%h", set_all, exp); end
  endtask

  task automatic test_timeout();
    int l0;
    l0 = load_cnt;
    set_cur(2023, 6, 15, 3, 12, 30, 0);
    press(1, 0, 0, 0);
    repeat (29) begin
      tick();
      @(negedge clk);
    end
    total++; if (hold !== 1'b1 || field_sel !== 3'd1) begin bad++; $display("FAIL pre_timeout got=%0b/%0d want=1/1", hold, field_sel); end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL blink_29 got=%0b want=1", blink); end
    tick();
    total++; if (hold !== 1'b0 || field_sel !== 3'd0) begin bad++; $display("FAIL timeout got=%0b/%0d want=0/0", hold, field_sel); end
    total++; if (blink !== 1'b0) begin bad++; $display("FAIL timeout_blink got=%0b want=0", blink); end
    total++; if (load_cnt != l0) begin bad++; $display("FAIL timeout_load got=%0d want=%0d", load_cnt, l0); end
  endtask

  task automatic test_priority();
    set_cur(2023, 6, 15, 3, 12, 30, 0);
    press(1, 0, 0, 0);
    press(0, 1, 1, 0);
    total++; if (field_sel !== 3'd2 || set_year !== 16'd2023) begin bad++; $display("FAIL next_over_up got=%0d/%0d want=2/2023", field_sel, set_year); end
    repeat (4) press(0, 1, 0, 0);
    total++; if (field_sel !== 3'd6) begin bad++; $display("FAIL min_sel got=%0d want=6", field_sel); end
    press(1, 0, 1, 0);
    total++; if (hold !== 1'b0 || field_sel !== 3'd0) begin bad++; $display("FAIL mode_over_up got=%0b/%0d want=0/0", hold, field_sel); end
    total++; if (set_minute !== 11'd30) begin bad++; $display("FAIL min_kept got=%0d want=30", set_minute); end
  endtask

  task automatic test_reset_mid();
    int l0;
    l0 = load_cnt;
    set_cur(2023, 6, 15, 3, 12, 30, 0);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    press(0, 1, 0, 0);
    press(0, 0, 1, 0);
    total++; if (field_sel !== 3'd3 || set_day !== 11'd16) begin bad++; $display("FAIL s_day got=%0d/%0d want=3/16", field_sel, set_day); end
    rst_n = 0;
    @(negedge clk);
    total++; if (hold !== 1'b0 || field_sel !== 3'd0) begin bad++; $display("FAIL mid_rst got=%0b/%0d want=0/0", hold, field_sel); end
    total++; if (set_all !== RST_VAL) begin bad++; $display("FAIL mid_rst_set got=%h want=%h", set_all, RST_VAL); end
    total++; if (load !== 1'b0 || load_cnt != l0) begin bad++; $display("FAIL mid_rst_load got=%0b want=0", load); end
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_run_ignore();
    test_leap_edit();
    test_feb_clamp();
    test_wrap();
    test_timeout();
    test_priority();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 The block SHALL have parameter YEAR_MIN, default 2000, lowest settable year.
REQ-002 The block SHALL have parameter YEAR_MAX, default 2099, highest settable year.
REQ-003 The block SHALL have parameter TIMEOUT_S, default 30, the number of idle tick_1hz pulses in edit mode before auto-abort.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset, with these ports:
- clk  in  1  system clock, all logic on its rising edge
- rst_n  in  1  synchronous active-low reset
REQ-005 It SHALL have these control inputs:
- tick_1hz  in  1  one-clk pulse per second
- btn_mode, btn_next, btn_up, btn_down  in  1 each  one-clk debounced pulses
REQ-006 It SHALL have these current-time inputs:
- cur_year  in  16
- cur_month  in  6
- cur_day, cur_week, cur_hour, cur_minute, cur_second  in  11 each
REQ-007 It SHALL have these set-value outputs:
- set_year  out  16
- set_month  out  6
- set_day, set_week, set_hour, set_minute, set_second  out  11 each
REQ-008 It SHALL have these status outputs:
- load  out  1  one-clk pulse; timekeeper loads set_* values
- hold  out  1  high while editing; timekeeper freezes counting
- field_sel  out  3  0=RUN, 1=YEAR, 2=MONTH, 3=DAY, 4=WEEK, 5=HOUR, 6=MIN, 7=SEC
- blink  out  1  display blink phase for the selected field

Function
REQ-009 The FSM SHALL have these states: RUN, S_YEAR, S_MONTH, S_DAY, S_WEEK, S_HOUR, S_MIN, S_SEC, COMMIT.
REQ-010 When several buttons pulse in the same cycle, only the highest-priority one SHALL act: mode > next > up > down.
REQ-011 On btn_mode in RUN, the block SHALL copy all cur_* into set_* and enter S_YEAR at the same edge, with hold=1 from the next cycle.
REQ-012 In RUN, the block SHALL ignore btn_next, btn_up and btn_down, and set_* SHALL keep their last values.
REQ-013 On btn_next in an S_ state, the block SHALL advance to the next field in the order YEAR, MONTH, DAY, WEEK, HOUR, MIN, SEC; btn_next in S_SEC SHALL enter COMMIT.
REQ-014 On btn_mode in any S_ state, the block SHALL abort: return to RUN, hold=0, no load pulse, and set_* frozen.
REQ-015 btn_up and btn_down SHALL adjust the selected field by +1 or -1 with wrap-around:
- year YEAR_MAX<->YEAR_MIN
- month 12<->1
- day dim<->1
- week 7<->1
- hour 23<->0
- minute and second 59<->0
REQ-016 dim (days in month) SHALL be 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; and for February 29 on a leap year, else 28.
REQ-017 A year SHALL be leap when divisible by 4 and not by 100, or when divisible by 400.
REQ-018 When a month or year edit makes set_day exceed the new dim, set_day SHALL be clamped to the new dim at the same clock edge.
REQ-019 COMMIT SHALL last exactly one cycle with load=1 and hold=1, then return to RUN; hold=0 the following cycle.
REQ-020 An idle counter SHALL clear on any button pulse and on entry to S_YEAR, and SHALL increment on each tick_1hz while in an S_ state.
REQ-021 When the idle counter reaches TIMEOUT_S, the block SHALL perform the same abort as REQ-014.
REQ-022 blink SHALL toggle on each tick_1hz while in an S_ state, SHALL be forced to 1 on any up/down pulse, and SHALL be 0 in RUN and COMMIT.
REQ-023 field_sel SHALL be a registered decode of the state, with RUN and COMMIT both mapping to 0.
REQ-024 The outputs load, hold, blink and field_sel SHALL all be registered, with no combinational input-to-output paths.

Reset
REQ-025 When rst_n=0 at a clk edge, state SHALL be RUN, load=0, hold=0, blink=0, field_sel=0, and the idle counter SHALL be 0.
REQ-026 On reset, set_* SHALL be 2023/5/9, week 2, 11:59:58.
REQ-027 Reset asserted mid-edit or in COMMIT SHALL override all other activity; no load pulse SHALL be issued in the reset cycle.

Verification
REQ-028 Set cur=2024/2/29 wk4 10:00:00, then mode, next, up -> set_month=3, set_day=29; then next, next, next, next, next, next -> exactly one load pulse with set=2024/3/29 wk4 10:00:00.
REQ-029 Set cur=2023/1/31, mode, next, up -> set_month=2, set_day=28; repeat with year 2000 -> set_day=29; repeat with year 2100 (YEAR_MAX raised) -> set_day=28.
REQ-030 In S_HOUR with hour=23, up -> 0; in S_YEAR with year=2000, down -> 2099; in S_WEEK with week=7, up -> 1.
REQ-031 Enter edit mode and issue no buttons for 30 tick_1hz pulses -> RUN, hold=0, load never asserted.
REQ-032 Pulse btn_mode and btn_up in the same cycle while in S_MIN -> abort, with no minute change.
REQ-033 Assert rst_n=0 during S_DAY -> next cycle state RUN, hold=0, set_* = reset values.
